// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - command/response codes, port states and the shared ALU function
package calc_pkg;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  localparam int CMD_ARG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_WAIT,
    ST_RESP
  } port_state_t;

  // Evaluated at 64 bits; dw is the live data width, result is {resp, data}.
  function automatic logic [65:0] calc_alu(
    input logic [CMD_ARG_W-1:0] cmd,
    input logic [63:0]          op1,
    input logic [63:0]          op2,
    input int unsigned          dw
  );
    logic [63:0] mask;
    logic [63:0] amt;
    logic [64:0] sum;
    logic [1:0]  resp;
    logic [63:0] res;
    mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    amt  = op2 & 64'(dw - 1);
    sum  = {1'b0, op1} + {1'b0, op2};
    resp = RESP_ERR;
    res  = '0;
    case (cmd)
      CMD_ARG_W'(CMD_ADD): begin
        if ((sum >> dw) == 65'd0) begin
          resp = RESP_OK;
          res  = sum[63:0];
        end
      end
      CMD_ARG_W'(CMD_SUB): begin
        if (op2 <= op1) begin
          resp = RESP_OK;
          res  = op1 - op2;
        end
      end
      CMD_ARG_W'(CMD_SHL): begin
        resp = RESP_OK;
        res  = (op1 << amt) & mask;
      end
      CMD_ARG_W'(CMD_SHR): begin
        resp = RESP_OK;
        res  = op1 >> amt;
      end
      default: begin
        resp = RESP_ERR;
        res  = '0;
      end
    endcase
    return {resp, res};
  endfunction

endpackage

// File: rtl/calc_rr_arbiter.sv
// rtl/calc_rr_arbiter.sv - round-robin one-hot arbiter owning its priority pointer
module calc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/calc_multi_port.sv
// rtl/calc_multi_port.sv - multi-port two-operand calculator sharing one ALU
module calc_multi_port
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 4
) (
  input  logic                        c_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
  output logic [NUM_PORTS*2-1:0]      out_resp,
  output logic [NUM_PORTS*DATA_W-1:0] out_data
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;

  calc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk   (c_clk),
    .rst_n (reset),
    .req   (req),
    .grant (grant)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    port_state_t       state;
    port_state_t       state_nxt;
    logic [CMD_W-1:0]  cmd_in;
    logic [DATA_W-1:0] data_in;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] data_q;
    logic [65:0]       alu_out;

    assign cmd_in  = req_cmd_in[p*CMD_W +: CMD_W];
    assign data_in = req_data_in[p*DATA_W +: DATA_W];
    assign req[p]  = (state == ST_WAIT);
    assign alu_out = calc_alu(CMD_ARG_W'(cmd_q), 64'(op1_q), 64'(op2_q), DATA_W);

    if (DATA_W < 64) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^alu_out[63:DATA_W];
    end

    always_comb begin
      state_nxt = state;
      case (state)
        ST_IDLE: if (cmd_in != '0) state_nxt = ST_OP2;
        ST_OP2:  state_nxt = ST_WAIT;
        ST_WAIT: if (grant[p]) state_nxt = ST_RESP;
        ST_RESP: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        state  <= ST_IDLE;
        cmd_q  <= '0;
        op1_q  <= '0;
        op2_q  <= '0;
        resp_q <= RESP_NONE;
        data_q <= '0;
      end else begin
        state <= state_nxt;
        case (state)
          ST_IDLE: begin
            if (cmd_in != '0) begin
              cmd_q <= cmd_in;
              op1_q <= data_in;
            end
          end
          ST_OP2: op2_q <= data_in;
          ST_WAIT: begin
            if (grant[p]) begin
              resp_q <= alu_out[65:64];
              data_q <= alu_out[DATA_W-1:0];
            end
          end
          ST_RESP: begin
            resp_q <= RESP_NONE;
            data_q <= '0;
          end
          default: begin
            resp_q <= RESP_NONE;
            data_q <= '0;
          end
        endcase
      end
    end

    assign out_resp[p*2 +: 2]           = resp_q;
    assign out_data[p*DATA_W +: DATA_W] = data_q;
  end

endmodule

// File: tb/tb_calc_multi_port.sv
// tb/tb_calc_multi_port.sv - self-checking bench for calc_multi_port
module tb_calc_multi_port;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic              c_clk = 1'b0;
  logic              reset = 1'b0;
  logic [NP*CW-1:0]  req_cmd_in = '0;
  logic [NP*DW-1:0]  req_data_in = '0;
  logic [NP*2-1:0]   out_resp;
  logic [NP*DW-1:0]  out_data;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  calc_multi_port #(.NUM_PORTS(NP), .DATA_W(DW), .CMD_W(CW)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  initial forever #5 c_clk = ~c_clk;

  // Behavioural model: per-port phase, operand capture, rotating priority.
  int              st  [NP];
  int              mc  [NP];
  longint unsigned mo1 [NP];
  longint unsigned mo2 [NP];
  int              mr  [NP];
  longint unsigned md  [NP];
  int              mptr;
  int              mg;

  function automatic void model_alu(input int c, input longint unsigned a,
                                    input longint unsigned b, output int r,
                                    output longint unsigned d);
    r = 2;
    d = 0;
    case (c)
      1: if (a + b <= 64'hFFFF_FFFF) begin r = 1; d = a + b; end
      2: if (b <= a) begin r = 1; d = a - b; end
      5: begin r = 1; d = (a << (b % 32)) & 64'hFFFF_FFFF; end
      6: begin r = 1; d = a >> (b % 32); end
      default: begin r = 2; d = 0; end
    endcase
  endfunction

  always @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      mptr = 0;
      for (int p = 0; p < NP; p++) begin
        st[p] = 0; mr[p] = 0; md[p] = 0;
      end
    end else begin
      mg = -1;
      for (int k = 0; k < NP; k++)
        if (mg < 0 && st[(mptr + k) % NP] == 2) mg = (mptr + k) % NP;
      for (int p = 0; p < NP; p++) begin
        case (st[p])
          0: if (req_cmd_in[p*CW +: CW] != 0) begin
               mc[p]  = int'(req_cmd_in[p*CW +: CW]);
               mo1[p] = 64'(req_data_in[p*DW +: DW]);
               st[p]  = 1;
             end
          1: begin mo2[p] = 64'(req_data_in[p*DW +: DW]); st[p] = 2; end
          2: if (p == mg) begin model_alu(mc[p], mo1[p], mo2[p], mr[p], md[p]); st[p] = 3; end
          default: begin mr[p] = 0; md[p] = 0; st[p] = 0; end
        endcase
      end
      if (mg >= 0) mptr = (mg + 1) % NP;
    end
  end

  logic [NP*2-1:0]  exp_resp;
  logic [NP*DW-1:0] exp_data;

  initial forever begin
    @(negedge c_clk);
    #1;
    if (started) begin
      for (int p = 0; p < NP; p++) begin
        exp_resp[p*2 +: 2]   = 2'(mr[p]);
        exp_data[p*DW +: DW] = 32'(md[p]);
      end
      tests++;
      if (out_resp !== exp_resp || out_data !== exp_data) begin
        fails++;
        $display("FAIL model_cmp t=%0t resp=%h expected %h data=%h expected %h",
                 $time, out_resp, exp_resp, out_data, exp_data);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input int c, input logic [31:0] d);
    req_cmd_in[p*CW +: CW]  = CW'(c);
    req_data_in[p*DW +: DW] = d;
  endtask

  task automatic issue(input int p, input int c, input logic [31:0] a, input logic [31:0] b);
    @(negedge c_clk); set_port(p, c, a);
    @(negedge c_clk); set_port(p, 0, b);
    @(negedge c_clk); set_port(p, 0, 0);
  endtask

  task automatic wait_resp(input int p, input int er, input logic [31:0] ed,
                           input int lat, input string name);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge c_clk);
      n++;
      if (out_resp[p*2 +: 2] != 2'd0) got = 1'b1;
    end
    if (!got) begin
      check({name, "_timeout"}, 64'(n), 64'(lat));
    end else begin
      check({name, "_resp"}, 64'(out_resp[p*2 +: 2]), 64'(er));
      check({name, "_data"}, 64'(out_data[p*DW +: DW]), 64'(ed));
      if (lat > 0) check({name, "_lat"}, 64'(n), 64'(lat));
    end
  endtask

  task automatic all_add_order(input string name);
    int first [NP];
    for (int p = 0; p < NP; p++) first[p] = -1;
    @(negedge c_clk); for (int p = 0; p < NP; p++) set_port(p, 1, 1);
    @(negedge c_clk); for (int p = 0; p < NP; p++) set_port(p, 0, 1);
    @(negedge c_clk); for (int p = 0; p < NP; p++) set_port(p, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge c_clk);
      for (int p = 0; p < NP; p++)
        if (out_resp[p*2 +: 2] != 2'd0 && first[p] < 0) first[p] = k;
    end
    for (int p = 0; p < NP; p++)
      check($sformatf("%s_p%0d_slot", name, p), 64'(first[p]), 64'(p + 1));
  endtask

  initial begin
    bit quiet;
    repeat (3) @(negedge c_clk);
    check("reset_resp", 64'(out_resp), 64'd0);
    check("reset_data", 64'(out_data[63:0] | out_data[127:64]), 64'd0);
    reset = 1'b1;
    started = 1'b1;

    issue(0, 1, 32'h5, 32'h3);
    wait_resp(0, 1, 32'h8, 1, "p0_add");
    check("p0_add_others", 64'(out_resp[7:2]), 64'd0);

    issue(1, 1, 32'hFFFF_FFFF, 32'h1);
    wait_resp(1, 2, 32'h0, 1, "p1_add_ovf");
    issue(2, 2, 32'd3, 32'd5);
    wait_resp(2, 2, 32'h0, 1, "p2_sub_under");
    issue(2, 2, 32'd5, 32'd5);
    wait_resp(2, 1, 32'h0, 1, "p2_sub_eq");
    issue(3, 5, 32'h1, 32'h21);
    wait_resp(3, 1, 32'h2, 1, "p3_shl");
    issue(3, 6, 32'h8000_0000, 32'd31);
    wait_resp(3, 1, 32'h1, 1, "p3_shr");
    issue(3, 3, 32'h7, 32'h7);
    wait_resp(3, 2, 32'h0, 1, "p3_invalid");

    all_add_order("rr1");
    all_add_order("rr2");

    // cmd held high through OP2/WAIT/RESP must not spawn extra work
    @(negedge c_clk); set_port(0, 1, 32'd7);
    @(negedge c_clk); set_port(0, 1, 32'd8);
    @(negedge c_clk); set_port(0, 1, 32'd100);
    @(negedge c_clk);
    check("hold_resp", 64'(out_resp[1:0]), 64'd1);
    check("hold_data", 64'(out_data[31:0]), 64'd15);
    set_port(0, 1, 32'd200);
    @(negedge c_clk); check("hold_gap1", 64'(out_resp[1:0]), 64'd0); set_port(0, 1, 32'd50);
    @(negedge c_clk); check("hold_gap2", 64'(out_resp[1:0]), 64'd0); set_port(0, 0, 32'd60);
    @(negedge c_clk); check("hold_gap3", 64'(out_resp[1:0]), 64'd0); set_port(0, 0, 32'd0);
    @(negedge c_clk);
    check("hold_next_resp", 64'(out_resp[1:0]), 64'd1);
    check("hold_next_data", 64'(out_data[31:0]), 64'd110);

    // reset while port3 is responding and port0 sits between op1 and op2
    @(negedge c_clk); set_port(3, 1, 32'd4);
    @(negedge c_clk); set_port(3, 0, 32'd4);
    @(negedge c_clk); set_port(3, 0, 32'd0); set_port(0, 1, 32'd9);
    @(negedge c_clk);
    check("pre_rst_p3_resp", 64'(out_resp[7:6]), 64'd1);
    check("pre_rst_p3_data", 64'(out_data[127:96]), 64'd8);
    reset = 1'b0;
    #1;
    check("rst_async_resp", 64'(out_resp), 64'd0);
    check("rst_async_data", 64'(out_data[63:0] | out_data[127:64]), 64'd0);
    set_port(0, 0, 32'd3);
    @(negedge c_clk); reset = 1'b1; set_port(0, 0, 32'd0);
    quiet = 1'b1;
    repeat (8) begin
      @(negedge c_clk);
      if (out_resp != '0) quiet = 1'b0;
    end
    check("rst_no_resp", 64'(quiet), 64'd1);
    issue(0, 1, 32'd2, 32'd2);
    wait_resp(0, 1, 32'd4, 1, "p0_after_rst");

    repeat (3) @(negedge c_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
